audio_dac_serializer: RTL and testbench
=======================================

Name: audio_dac_serializer

Overview:
- Output end of the piano audio path: takes the 32-bit signed mixed sound sample produced by the key-to-sound mixer and serializes it to the board audio codec DAC in I2S format.
- Generates the codec bit clock (BCLK), left/right clock (DACLRCK) and serial data (DACDAT) from the system clock.
- Buffers samples in a small FIFO with a valid/ready handshake, and sends the same mono sample on both channels.

Parameters:
- SAMPLE_W, 32, bits per channel sample; the MSB is sent first.
- BCLK_DIV, 8, clk cycles per BCLK half-period. BCLK period is 2*BCLK_DIV clk.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start/stop serializing.
- sample_in  in  SAMPLE_W  signed sample (the mixer's sound output).
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a sample (not full).
- aud_bclk  out  1  codec bit clock.
- aud_daclrck  out  1  0 = left channel, 1 = right channel.
- aud_dacdat  out  1  serial data.
- underrun  out  1  sticky flag: a frame started with the FIFO empty.
- underrun_clr  in  1  clears underrun.
- busy  out  1  state is RUN.

Behaviour:
- Reset is synchronous, active-high, single clock domain. Reset values:
  - state IDLE
  - FIFO empty, so sample_ready=1
  - aud_bclk=0, aud_daclrck=0, aud_dacdat=0
  - underrun=0, busy=0
  - div_cnt=0, slot=0, shift word=0
- Reset mid-frame aborts immediately; no frame completion.
- FIFO:
  - Write when sample_valid && sample_ready.
  - sample_ready = !full.
  - Pop only at a frame load.
  - A write and a pop in the same cycle are both performed.
  - There is no write-to-load bypass: a load in the same cycle as a write to an empty FIFO sees empty.
- State IDLE:
  - Outputs are held at their reset values except underrun, and the FIFO still accepts writes.
  - When enable=1, go to RUN next cycle. That transition cycle also performs the first frame load, with slot=0, div_cnt=0, aud_bclk=0, aud_daclrck=0 and aud_dacdat=0.
- State RUN:
  - div_cnt counts 0..BCLK_DIV-1. At terminal count, aud_bclk toggles and div_cnt wraps to 0.
  - A rising edge only toggles aud_bclk.
  - A falling edge (aud_bclk 1->0) advances slot, which runs 0..2*SAMPLE_W-1, and updates aud_daclrck and aud_dacdat in that same cycle.
  - aud_daclrck = 0 for slots 0..SAMPLE_W-1 and 1 for slots SAMPLE_W..2*SAMPLE_W-1.
- Frame word and I2S data timing:
  - Frame word W = {S, S}, where S is the loaded sample; 2*SAMPLE_W bits, left channel then right.
  - I2S one-slot delay: during slot n>=1, aud_dacdat = W[2*SAMPLE_W-n].
  - During slot 0, aud_dacdat = the previous frame's W[0], which is 0 for the first frame after IDLE.
- Frame load:
  - Occurs on the falling edge where slot wraps 2*SAMPLE_W-1 -> 0, and on IDLE->RUN entry.
  - If the FIFO is not empty, pop and S = head.
  - If the FIFO is empty, S = 0 and underrun is set.
- underrun:
  - Is set the cycle after the load.
  - underrun_clr clears it. If a set and a clear happen in the same cycle, set wins.
- Stopping:
  - enable=0 in RUN does not stop immediately. The current frame completes.
  - At the next frame-wrap falling edge, go to IDLE instead of loading; there is no pop.
  - In that cycle aud_bclk=0, aud_daclrck=0, aud_dacdat=the last frame's W[0] for one cycle, then 0.
  - If enable returns to 1 before the wrap, the stop is cancelled.
- Rates:
  - Frame = 2*SAMPLE_W*2*BCLK_DIV clk = 1024 clk at the defaults.
  - At a 50 MHz clk this is 48.83 kHz.
- Sample width: sample_in is taken raw. No scaling or saturation; the upstream mixer guarantees the range.

Optional Feature:
- Macro: AUDIO_LEFT_JUSTIFIED_EN.
- Defined: left-justified format with no one-slot delay. During slot n, aud_dacdat = W[2*SAMPLE_W-1-n]. In slot 0 this is the MSB of the new sample, and the stop cycle outputs 0.
- Undefined: I2S timing as specified in Behaviour. Ports and all other timing are unchanged.

Test Plan:
- Reset with a write pending: assert reset for 2 cycles with sample_valid=1 -> all outputs at reset values, FIFO still empty, sample_ready=1; no write accepted during reset.
- Basic frame: write 32'h8000_0001, then enable=1 -> busy=1. aud_bclk first rises 8 clk after RUN entry. Slots 1..32 carry 1,0,...,0,1; slots 33..64 (slot 0 of the next frame) repeat the pattern. aud_daclrck rises at slot 32, i.e. 512 clk after entry. underrun stays 0 until the next frame load, where it sets because the FIFO is empty.
- Underrun: enable with the FIFO empty -> underrun=1 one cycle after RUN entry and aud_dacdat=0 all frame. Pulse underrun_clr -> underrun=0 until the next empty load. Set and clear in the same cycle -> underrun=1.
- FIFO full / backpressure: write 5 samples back-to-back with enable=0 -> sample_ready drops after the 4th, 5th not accepted. Enable -> the 4 samples are sent in order over 4 frames; sample_ready rises the cycle after the first pop.
- Graceful stop: drop enable mid-frame at slot 10 -> frame completes through slot 63. IDLE on the wrap falling edge with no pop (FIFO count unchanged). aud_bclk stays 0 afterwards.
- AUDIO_LEFT_JUSTIFIED_EN build, sample 32'hC000_0000: slot 0 aud_dacdat=1, slot 1 =1, slot 2 =0; slot 32 =1 with aud_daclrck=1.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: FIFO-buffered mono sample to codec serializer, I2S by default, left-justified when AUDIO_LEFT_JUSTIFIED_EN is defined
module audio_dac_serializer #(
   parameter int SAMPLE_W   = 32,
   parameter int BCLK_DIV   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                aud_bclk,
   output logic                aud_daclrck,
   output logic                aud_dacdat,
   output logic                underrun,
   input  logic                underrun_clr,
   output logic                busy
);
`ifdef AUDIO_LEFT_JUSTIFIED_EN
   localparam bit LJ = 1'b1;
`else
   localparam bit LJ = 1'b0;
`endif
   localparam int FRAME_W = 2 * SAMPLE_W;
   localparam int SLOT_W  = $clog2(FRAME_W);
   localparam int DIV_W   = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr, rd_ptr;
   logic [DIV_W-1:0]    div_cnt;
   logic [SLOT_W-1:0]   slot, bit_idx;
   logic [FRAME_W-1:0]  word;
   logic [SAMPLE_W-1:0] new_s;
   logic                empty, full, push, pop, tick, wrap, load;

   assign empty        = wr_ptr == rd_ptr;
   assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign sample_ready = !full;
   assign push         = sample_valid && sample_ready && !reset;

   // Frame sequencing decisions; a load never sees a same-cycle write
   always_comb begin
      tick    = state == RUN && div_cnt == DIV_W'(BCLK_DIV - 1);
      wrap    = tick && aud_bclk && slot == SLOT_W'(FRAME_W - 1);
      load    = enable && (state == IDLE || wrap);
      pop     = load && !empty;
      new_s   = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
      bit_idx = LJ ? SLOT_W'(FRAME_W - 2) - slot : SLOT_W'(FRAME_W - 1) - slot;
   end

   // Sample storage; occupancy lives in the pointers so the array needs no reset
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[PTR_W-1:0]] <= sample_in;

   // Control FSM, bit clock divider, slot counter and registered codec outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         div_cnt     <= '0;
         slot        <= '0;
         word        <= '0;
         aud_bclk    <= 1'b0;
         aud_daclrck <= 1'b0;
         aud_dacdat  <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         underrun <= (load && empty) || (underrun && !underrun_clr);
         if (load) begin
            state       <= RUN;
            busy        <= 1'b1;
            div_cnt     <= '0;
            slot        <= '0;
            word        <= {new_s, new_s};
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= LJ ? new_s[SAMPLE_W-1] : (state == RUN) && word[0];
         end else if (state == IDLE) begin
            div_cnt     <= '0;
            slot        <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
         end else if (wrap) begin
            state       <= IDLE;
            busy        <= 1'b0;
            div_cnt     <= '0;
            slot        <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= !LJ && word[0];
         end else if (tick) begin
            div_cnt  <= '0;
            aud_bclk <= !aud_bclk;
            if (aud_bclk) begin
               slot        <= slot + 1'b1;
               aud_daclrck <= slot >= SLOT_W'(SAMPLE_W - 1);
               aud_dacdat  <= word[bit_idx];
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: directed bench with a time-based frame model checked every cycle
module tb_audio_dac_serializer;
`ifdef AUDIO_LEFT_JUSTIFIED_EN
   localparam bit LJ = 1'b1;
`else
   localparam bit LJ = 1'b0;
`endif
   localparam int SW    = 32;
   localparam int DIV   = 8;
   localparam int DEPTH = 4;
   localparam int FRAME = 2 * SW * 2 * DIV;

   logic          clk = 1'b0;
   logic          reset, enable, sample_valid, underrun_clr;
   logic [SW-1:0] sample_in;
   logic          sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun, busy;

   int checks   = 0;
   int failures = 0;
   bit go       = 1'b0;

   // model: frame position is plain elapsed-cycle arithmetic since the frame load
   bit            m_run = 1'b0;
   int            m_k   = 0;
   logic [SW-1:0] m_cur = '0;
   logic          m_prev0 = 1'b0, m_flash = 1'b0, m_unr = 1'b0;
   logic [SW-1:0] q[$];

   audio_dac_serializer #(.SAMPLE_W(SW), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .aud_bclk(aud_bclk),
      .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat), .underrun(underrun),
      .underrun_clr(underrun_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // model update on each edge, then the whole output set compared 1 time unit later
   initial begin
      logic          ld, emp, rdy, e_dat;
      logic [2*SW-1:0] w;
      logic [5:0]    got, exp;
      int            s;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_run = 1'b0; m_k = 0; m_unr = 1'b0; m_flash = 1'b0; q.delete();
         end else begin
            emp = q.size() == 0;
            rdy = q.size() < DEPTH;
            ld = 1'b0;
            m_flash = 1'b0;
            if (!m_run) begin
               if (enable) begin ld = 1'b1; m_run = 1'b1; m_k = 0; m_prev0 = 1'b0; end
            end else if (m_k + 1 == FRAME) begin
               if (enable) begin ld = 1'b1; m_k = 0; m_prev0 = m_cur[0]; end
               else begin m_run = 1'b0; m_flash = LJ ? 1'b0 : m_cur[0]; end
            end else m_k++;
            if (ld) begin
               if (emp) m_cur = '0;
               else m_cur = q.pop_front();
            end
            m_unr = (ld && emp) || (m_unr && !underrun_clr);
            if (sample_valid && rdy) q.push_back(sample_in);
         end
         #1;
         if (go) begin
            if (m_run) begin
               s = m_k / (2 * DIV);
               w = {m_cur, m_cur};
               e_dat = LJ ? w[2*SW-1-s] : (s == 0 ? m_prev0 : w[2*SW-s]);
               exp = {q.size() < DEPTH, (m_k / DIV) % 2 == 1, s >= SW, e_dat, m_unr, 1'b1};
            end else begin
               exp = {q.size() < DEPTH, 1'b0, 1'b0, m_flash, m_unr, 1'b0};
            end
            got = {sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun, busy};
            checks++;
            if (got !== exp) begin
               failures++;
               if (failures <= 20)
                  $display("FAIL cycle {rdy,bclk,lrck,dat,unr,busy} got=%b exp=%b k=%0d at %0t", got, exp, m_k, $time);
            end
         end
      end
   end

   initial begin
      logic [SW-1:0] a_s [5];
      a_s = '{32'h1234_5678, 32'hA5A5_0F0F, 32'h7FFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF};
      reset = 1'b1; enable = 1'b0; underrun_clr = 1'b0;
      sample_valid = 1'b1; sample_in = 32'hDEAD_BEEF;
      step(2);
      chk("reset_ready", sample_ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_bclk", aud_bclk, 1'b0);
      chk("reset_dat", aud_dacdat, 1'b0);
      chk("reset_unr", underrun, 1'b0);
      reset = 1'b0; sample_valid = 1'b0; go = 1'b1;
      // basic frame
      step(1); sample_valid = 1'b1; sample_in = 32'h8000_0001;
      step(1); sample_valid = 1'b0; enable = 1'b1;
      step(1);
      chk("entry_busy", busy, 1'b1);
      chk("entry_unr", underrun, 1'b0);
      chk("slot0_dat", aud_dacdat, LJ);
      step(7);  chk("bclk_k7", aud_bclk, 1'b0);
      step(1);  chk("bclk_k8", aud_bclk, 1'b1);
      step(8);  chk("slot1_dat", aud_dacdat, !LJ);
      step(16); chk("slot2_dat", aud_dacdat, 1'b0);
      step(479); chk("lrck_k511", aud_daclrck, 1'b0);
      step(1);  chk("lrck_k512", aud_daclrck, 1'b1);
      chk("slot32_dat", aud_dacdat, 1'b1);
      step(16); chk("slot33_dat", aud_dacdat, !LJ);
      step(495); chk("unr_before_wrap", underrun, 1'b0);
      step(1);  chk("unr_empty_load", underrun, 1'b1);
      chk("f2_slot0_dat", aud_dacdat, !LJ);
      // underrun clear, then set and clear together
      step(5); underrun_clr = 1'b1;
      step(1); underrun_clr = 1'b0;
      chk("unr_cleared", underrun, 1'b0);
      step(1017); chk("unr_still_clear", underrun, 1'b0);
      underrun_clr = 1'b1;
      step(1); underrun_clr = 1'b0;
      chk("unr_set_wins", underrun, 1'b1);
      // graceful stop from slot 10
      step(160); enable = 1'b0;
      step(863); chk("stop_still_busy", busy, 1'b1);
      step(1);  chk("stop_idle", busy, 1'b0);
      chk("stop_bclk", aud_bclk, 1'b0);
      step(20); chk("idle_bclk", aud_bclk, 1'b0);
      chk("idle_unr_sticky", underrun, 1'b1);
      underrun_clr = 1'b1;
      step(1); underrun_clr = 1'b0;
      // backpressure: fifth write rejected
      for (int i = 0; i < 5; i++) begin
         sample_valid = 1'b1; sample_in = a_s[i];
         step(1);
         if (i == 3) chk("full_after_4", sample_ready, 1'b0);
      end
      sample_valid = 1'b0;
      chk("still_full", sample_ready, 1'b0);
      enable = 1'b1;
      step(1);
      chk("ready_after_pop", sample_ready, 1'b1);
      chk("bp_busy", busy, 1'b1);
      // stop request cancelled before the wrap
      step(1224); enable = 1'b0;
      step(700); enable = 1'b1;
      step(124); chk("cancel_busy", busy, 1'b1);
      step(1124); sample_valid = 1'b1; sample_in = 32'hC000_0000;
      step(1); sample_valid = 1'b0;
      step(59); enable = 1'b0;
      step(864);
      chk("stop2_idle", busy, 1'b0);
      chk("stop2_flash", aud_dacdat, !LJ);
      step(1); chk("stop2_dat0", aud_dacdat, 1'b0);
      chk("stop2_no_pop", sample_ready, 1'b1);
      // queued sample survives the stop and is sent without underrun
      enable = 1'b1;
      step(1);
      chk("reentry_unr", underrun, 1'b0);
      chk("c0_slot0", aud_dacdat, LJ);
      step(16); chk("c0_slot1", aud_dacdat, 1'b1);
      step(16); chk("c0_slot2", aud_dacdat, !LJ);
      step(16); chk("c0_slot3", aud_dacdat, 1'b0);
      step(464); chk("c0_slot32_lrck", aud_daclrck, 1'b1);
      chk("c0_slot32", aud_dacdat, LJ);
      enable = 1'b0;
      step(512); chk("final_idle", busy, 1'b0);
      step(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
